imem_loader: RTL

- Program loader that sits directly upstream of the instruction memory (imem) write port.
- Takes a byte stream from the debug UART receiver and assembles it into 32-bit instruction words, MSB first.
- Writes each word into imem at consecutive word addresses starting at 0.
- Stops when the HALT word 0xFFFFFFFF has been written, or flags an error if memory fills first.

---
 rtl/imem_loader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream to instruction-word loader feeding the imem write port (MSB-first, word addresses from 0).
// Optional inter-byte timeout is compiled in when LOADER_TIMEOUT_EN is defined.
module imem_loader #(
    parameter int                 NB_DATA        = 32,
    parameter int                 NB_BYTE        = 8,
    parameter int                 NB_ADDR        = 32,
    parameter int                 MEM_DEPTH      = 128,
    parameter logic [NB_DATA-1:0] HALT_WORD      = {NB_DATA{1'b1}},
    parameter int                 TIMEOUT_CYCLES = 100000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_rx_valid,
    input  logic [NB_BYTE-1:0] i_rx_data,
    output logic               o_en_write,
    output logic [NB_ADDR-1:0] o_addr,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow,
    output logic [NB_ADDR-1:0] o_word_count
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEM_DEPTH - 1);

    if (NB_DATA != 4 * NB_BYTE || MEM_DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("imem_loader: invalid parameter set");
    end

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [1:0]                 byte_cnt;
    logic [NB_DATA-NB_BYTE-1:0] shift_reg;
    logic                       timeout;
    logic                       byte_accept;

    // Bytes are taken in RECV and also during the single WRITE cycle, so back-to-back strobes lose nothing.
    assign byte_accept = i_rx_valid && (state == RECV || state == WRITE);

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    assign timeout = (state == RECV) && (byte_cnt != 2'd0) && !i_rx_valid &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tmo_cnt <= '0;
        end else if (state != RECV || byte_cnt == 2'd0 || i_rx_valid) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_W'(TIMEOUT_CYCLES)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (i_start) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (timeout) begin
                    state_next = ERR;
                end else if (i_rx_valid && byte_cnt == 2'd3) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (o_data == HALT_WORD) begin
                    state_next = DONE;
                end else if (o_addr == LAST_ADDR) begin
                    state_next = ERR;
                end else begin
                    state_next = RECV;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Partial-word bytes; no reset needed since byte_cnt qualifies their use.
    always_ff @(posedge i_clk) begin
        if (byte_accept) begin
            shift_reg <= {shift_reg[NB_DATA-2*NB_BYTE-1:0], i_rx_data};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            byte_cnt     <= 2'd0;
            o_en_write   <= 1'b0;
            o_addr       <= '0;
            o_data       <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_overflow   <= 1'b0;
            o_word_count <= '0;
        end else begin
            o_en_write <= (state_next == WRITE);
            o_busy     <= (state_next == RECV) || (state_next == WRITE);
            o_done     <= (state_next == DONE);
            o_overflow <= (state_next == ERR);
            case (state)
                IDLE, DONE, ERR: begin
                    if (i_start) begin
                        o_addr       <= '0;
                        o_word_count <= '0;
                        byte_cnt     <= 2'd0;
                    end
                end
                RECV: begin
                    if (timeout) begin
                        byte_cnt <= 2'd0;
                    end else if (i_rx_valid) begin
                        if (byte_cnt == 2'd3) begin
                            o_data   <= {shift_reg, i_rx_data};
                            byte_cnt <= 2'd0;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    o_word_count <= o_word_count + NB_ADDR'(1);
                    if (o_data != HALT_WORD && o_addr != LAST_ADDR) begin
                        o_addr <= o_addr + NB_ADDR'(1);
                    end
                    if (i_rx_valid) begin
                        byte_cnt <= 2'd1;
                    end
                end
                default: byte_cnt <= 2'd0;
            endcase
        end
    end

endmodule
